branch_predictor_btb_ras: RTL and testbench

BRANCH_PREDICTOR_BTB_RAS -- requirements
Module: branch_predictor_btb_ras

---
 rtl/branch_predictor_btb_ras.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_branch_predictor_btb_ras.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_btb_ras.sv
// ---------------------------------------------------------------------------
// branch_predictor_btb_ras
//
// Fetch-stage branch predictor built from a direct-mapped branch target
// buffer (BTB) with a 2-bit saturating counter per entry and a small
// circular return-address stack (RAS). Prediction is purely combinational
// from registered state. Training happens from the EX stage, one resolved
// control-transfer instruction per cycle.
//
// Parameters
//   ENTRIES    BTB/BHT entry count, power of two in [4, 256]
//   RAS_DEPTH  return-address-stack depth, power of two in [2, 16]
//
// Ports
//   clk_i             clock, all state updates on the rising edge
//   rst_i             synchronous active-high reset
//   pc_i              fetch PC to predict
//   pred_taken_o      predicted direction for pc_i
//   pred_target_o     predicted next PC for pc_i
//   ex_valid_i        a control-transfer instruction resolves this cycle
//   pc_ex_i           PC of the resolving instruction
//   inst_ex_i         encoding of the resolving instruction
//   taken_ex_i        actual direction
//   target_ex_i       actual target
//   pred_taken_ex_i   fetch-time direction prediction for it
//   pred_target_ex_i  fetch-time target prediction for it
//   mispredict_o      flush request (combinational)
//   redirect_pc_o     correct next PC for the resolving instruction
//   branch_cnt_o      number of resolved instructions
//   mispred_cnt_o     number of mispredicted instructions
// ---------------------------------------------------------------------------
module branch_predictor_btb_ras #(
  parameter int ENTRIES   = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] pc_i,
  output logic        pred_taken_o,
  output logic [31:0] pred_target_o,
  input  logic        ex_valid_i,
  input  logic [31:0] pc_ex_i,
  input  logic [31:0] inst_ex_i,
  input  logic        taken_ex_i,
  input  logic [31:0] target_ex_i,
  input  logic        pred_taken_ex_i,
  input  logic [31:0] pred_target_ex_i,
  output logic        mispredict_o,
  output logic [31:0] redirect_pc_o,
  output logic [31:0] branch_cnt_o,
  output logic [31:0] mispred_cnt_o
);

  localparam int IDX  = $clog2(ENTRIES);
  localparam int TAGW = 30 - IDX;
  localparam int RP   = $clog2(RAS_DEPTH);

  // Entry type encoding; 2'b11 is never written.
  localparam logic [1:0] T_BR   = 2'd0;
  localparam logic [1:0] T_JUMP = 2'd1;
  localparam logic [1:0] T_RET  = 2'd2;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [RP:0] RAS_FULL = (RP+1)'(RAS_DEPTH);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic            valid_q  [ENTRIES];
  logic [TAGW-1:0] tag_q    [ENTRIES];
  logic [31:0]     target_q [ENTRIES];
  logic [1:0]      type_q   [ENTRIES];
  logic [1:0]      ctr_q    [ENTRIES];

  logic [31:0]     ras_q [RAS_DEPTH];
  logic [RP-1:0]   ras_ptr_q;   // next free slot; top lives at ras_ptr_q-1
  logic [RP:0]     ras_cnt_q;

  logic [31:0]     branch_cnt_q;
  logic [31:0]     mispred_cnt_q;

  // -------------------------------------------------------------------------
  // Fetch-side lookup
  // -------------------------------------------------------------------------
  logic [IDX-1:0]  f_idx;
  logic [TAGW-1:0] f_tag;
  logic            f_hit;
  logic [31:0]     f_pc_plus4;
  logic [31:0]     ras_top;
  logic            ras_empty;

  assign f_idx      = pc_i[IDX+1:2];
  assign f_tag      = pc_i[31:IDX+2];
  assign f_hit      = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign f_pc_plus4 = pc_i + 32'd4;
  assign ras_top    = ras_q[ras_ptr_q - RP'(1)];
  assign ras_empty  = (ras_cnt_q == '0);

  always_comb begin
    pred_taken_o  = 1'b0;
    pred_target_o = f_pc_plus4;
    if (f_hit) begin
      case (type_q[f_idx])
        T_BR: begin
          pred_taken_o  = ctr_q[f_idx][1];
          pred_target_o = ctr_q[f_idx][1] ? target_q[f_idx] : f_pc_plus4;
        end
        T_JUMP: begin
          pred_taken_o  = 1'b1;
          pred_target_o = target_q[f_idx];
        end
        T_RET: begin
          // An empty stack falls back to the last target seen at this PC.
          pred_taken_o  = 1'b1;
          pred_target_o = ras_empty ? target_q[f_idx] : ras_top;
        end
        default: begin
          pred_taken_o  = 1'b0;
          pred_target_o = f_pc_plus4;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // EX-side decode
  // -------------------------------------------------------------------------
  logic [6:0] opcode;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic       is_jal;
  logic       is_jalr;
  logic       rd_link;
  logic       rs1_link;
  logic [1:0] dec_type;

  assign opcode   = inst_ex_i[6:0];
  assign rd       = inst_ex_i[11:7];
  assign rs1      = inst_ex_i[19:15];
  assign is_jal   = (opcode == OP_JAL);
  assign is_jalr  = (opcode == OP_JALR);
  assign rd_link  = (rd == 5'd1) || (rd == 5'd5);
  assign rs1_link = (rs1 == 5'd1) || (rs1 == 5'd5);

  // Anything that is not a jump is trained as a conditional branch; the core
  // only presents control transfers here, so OP_BRANCH is the expected case.
  always_comb begin
    dec_type = T_BR;
    if (is_jalr && (rd == 5'd0) && rs1_link) begin
      dec_type = T_RET;
    end else if (is_jal || is_jalr) begin
      dec_type = T_JUMP;
    end else if (opcode == OP_BRANCH) begin
      dec_type = T_BR;
    end
  end

  // -------------------------------------------------------------------------
  // BTB update
  // -------------------------------------------------------------------------
  logic [IDX-1:0]  ex_idx;
  logic [TAGW-1:0] ex_tag;
  logic            ex_hit;
  logic [1:0]      ex_ctr;
  logic [1:0]      ctr_inc;
  logic [1:0]      ctr_dec;
  logic            btb_we;       // valid/counter write
  logic            btb_full_we;  // tag/target/type write (taken only)
  logic [1:0]      ctr_d;

  assign ex_idx  = pc_ex_i[IDX+1:2];
  assign ex_tag  = pc_ex_i[31:IDX+2];
  assign ex_hit  = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign ex_ctr  = ctr_q[ex_idx];
  assign ctr_inc = (ex_ctr == 2'b11) ? 2'b11 : ex_ctr + 2'b01;
  assign ctr_dec = (ex_ctr == 2'b00) ? 2'b00 : ex_ctr - 2'b01;

  // Not-taken misses write nothing, so a not-taken branch never evicts.
  assign btb_we      = ex_valid_i && (taken_ex_i || ex_hit);
  assign btb_full_we = ex_valid_i && taken_ex_i;

  always_comb begin
    ctr_d = ex_ctr;
    if (taken_ex_i && !ex_hit) begin
      ctr_d = 2'b10;
    end else if (dec_type == T_BR) begin
      ctr_d = taken_ex_i ? ctr_inc : ctr_dec;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
    end else if (btb_we) begin
      valid_q[ex_idx] <= 1'b1;
      ctr_q[ex_idx]   <= ctr_d;
    end
  end

  // Payload fields need no reset: they are only observed behind valid_q.
  always_ff @(posedge clk_i) begin
    if (!rst_i && btb_full_we) begin
      tag_q[ex_idx]    <= ex_tag;
      target_q[ex_idx] <= target_ex_i;
      type_q[ex_idx]   <= dec_type;
    end
  end

  // -------------------------------------------------------------------------
  // Return-address stack
  // -------------------------------------------------------------------------
  logic          ras_push;
  logic          ras_pop;
  logic          ras_do_pop;
  logic          ras_we;
  logic [RP-1:0] ras_waddr;
  logic [31:0]   ras_wdata;
  logic [RP-1:0] ras_ptr_d;
  logic [RP:0]   ras_cnt_d;

  assign ras_push   = ex_valid_i && (is_jal || is_jalr) && rd_link;
  // Plain returns pop; a link-to-link JALR pops and pushes (coroutine swap).
  assign ras_pop    = ex_valid_i && is_jalr && rs1_link && ((rd == 5'd0) || rd_link);
  assign ras_do_pop = ras_pop && !ras_empty;
  assign ras_wdata  = pc_ex_i + 32'd4;

  always_comb begin
    ras_we    = 1'b0;
    ras_waddr = ras_ptr_q;
    ras_ptr_d = ras_ptr_q;
    ras_cnt_d = ras_cnt_q;
    if (ras_push && ras_do_pop) begin
      // Replace the top in place; depth is unchanged.
      ras_we    = 1'b1;
      ras_waddr = ras_ptr_q - RP'(1);
    end else if (ras_push) begin
      // When full the pointer already sits on the oldest entry, so the
      // write overwrites it and the count just saturates.
      ras_we    = 1'b1;
      ras_waddr = ras_ptr_q;
      ras_ptr_d = ras_ptr_q + RP'(1);
      ras_cnt_d = (ras_cnt_q == RAS_FULL) ? ras_cnt_q : ras_cnt_q + (RP+1)'(1);
    end else if (ras_do_pop) begin
      ras_ptr_d = ras_ptr_q - RP'(1);
      ras_cnt_d = ras_cnt_q - (RP+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ras_ptr_q <= '0;
      ras_cnt_q <= '0;
    end else begin
      ras_ptr_q <= ras_ptr_d;
      ras_cnt_q <= ras_cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && ras_we) begin
      ras_q[ras_waddr] <= ras_wdata;
    end
  end

  // -------------------------------------------------------------------------
  // Resolution outputs and performance counters
  // -------------------------------------------------------------------------
  assign mispredict_o  = ex_valid_i &&
                         ((taken_ex_i != pred_taken_ex_i) ||
                          (taken_ex_i && (target_ex_i != pred_target_ex_i)));
  assign redirect_pc_o = taken_ex_i ? target_ex_i : pc_ex_i + 32'd4;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (ex_valid_i) begin
        branch_cnt_q <= branch_cnt_q + 32'd1;
      end
      if (mispredict_o) begin
        mispred_cnt_q <= mispred_cnt_q + 32'd1;
      end
    end
  end

  assign branch_cnt_o  = branch_cnt_q;
  assign mispred_cnt_o = mispred_cnt_q;

  // Immediate/funct fields and the byte offset play no part in prediction.
  logic unused_bits;
  assign unused_bits = ^{inst_ex_i[31:20], inst_ex_i[14:12], pc_i[1:0], pc_ex_i[1:0]};

endmodule

// File: tb/tb_branch_predictor_btb_ras.sv
module tb_branch_predictor_btb_ras;

  logic        clk;
  logic        rst;
  logic [31:0] pc_i;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic        ex_valid_i;
  logic [31:0] pc_ex_i;
  logic [31:0] inst_ex_i;
  logic        taken_ex_i;
  logic [31:0] target_ex_i;
  logic        pred_taken_ex_i;
  logic [31:0] pred_target_ex_i;
  logic        mispredict_o;
  logic [31:0] redirect_pc_o;
  logic [31:0] branch_cnt_o;
  logic [31:0] mispred_cnt_o;

  int checks;
  int failures;

  localparam logic [31:0] BEQ      = 32'h0000_0063;
  localparam logic [31:0] JAL_X1   = 32'h0000_00EF;
  localparam logic [31:0] RET      = 32'h0000_8067;  // jalr x0, 0(x1)
  localparam logic [31:0] JALR_X1X1 = 32'h0000_80E7; // jalr x1, 0(x1)

  branch_predictor_btb_ras #(.ENTRIES(32), .RAS_DEPTH(4)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .pc_i             (pc_i),
    .pred_taken_o     (pred_taken_o),
    .pred_target_o    (pred_target_o),
    .ex_valid_i       (ex_valid_i),
    .pc_ex_i          (pc_ex_i),
    .inst_ex_i        (inst_ex_i),
    .taken_ex_i       (taken_ex_i),
    .target_ex_i      (target_ex_i),
    .pred_taken_ex_i  (pred_taken_ex_i),
    .pred_target_ex_i (pred_target_ex_i),
    .mispredict_o     (mispredict_o),
    .redirect_pc_o    (redirect_pc_o),
    .branch_cnt_o     (branch_cnt_o),
    .mispred_cnt_o    (mispred_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        exp_pt;
    logic [31:0] exp_ptgt;
    logic        exv;
    logic [31:0] pcex;
    logic [31:0] inst;
    logic        tk;
    logic [31:0] tgt;
    logic        ptk;
    logic [31:0] ptgt;
    logic        exp_mis;
    logic [31:0] exp_redir;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [31:0] pc, input logic exp_pt, input logic [31:0] exp_ptgt,
                              input logic exv, input logic [31:0] pcex, input logic [31:0] inst,
                              input logic tk, input logic [31:0] tgt, input logic ptk,
                              input logic [31:0] ptgt, input logic exp_mis, input logic [31:0] exp_redir);
    vec_t v;
    v.pc = pc; v.exp_pt = exp_pt; v.exp_ptgt = exp_ptgt; v.exv = exv; v.pcex = pcex;
    v.inst = inst; v.tk = tk; v.tgt = tgt; v.ptk = ptk; v.ptgt = ptgt;
    v.exp_mis = exp_mis; v.exp_redir = exp_redir;
    return v;
  endfunction

  // Idle EX slot: all EX fields zero, so redirect is 0+4.
  function automatic vec_t idle(input logic [31:0] pc, input logic exp_pt, input logic [31:0] exp_ptgt);
    return mk(pc, exp_pt, exp_ptgt, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h4);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%08h required=%08h", nm, act, exp);
    end
  endtask

  task automatic apply_vec(input vec_t v, input string nm);
    @(negedge clk);
    pc_i             = v.pc;
    ex_valid_i       = v.exv;
    pc_ex_i          = v.pcex;
    inst_ex_i        = v.inst;
    taken_ex_i       = v.tk;
    target_ex_i      = v.tgt;
    pred_taken_ex_i  = v.ptk;
    pred_target_ex_i = v.ptgt;
    #1;
    chk({nm, ".pred_taken"},  {31'b0, pred_taken_o}, {31'b0, v.exp_pt});
    chk({nm, ".pred_target"}, pred_target_o, v.exp_ptgt);
    chk({nm, ".mispredict"},  {31'b0, mispredict_o}, {31'b0, v.exp_mis});
    if (v.exv) chk({nm, ".redirect"}, redirect_pc_o, v.exp_redir);
    $display("txn %s pc=%08h pred=%0d/%08h ex=%0d mis=%0d redir=%08h", nm, v.pc,
             pred_taken_o, pred_target_o, v.exv, mispredict_o, redirect_pc_o);
  endtask

  task automatic clear_ex();
    ex_valid_i = 1'b0; pc_ex_i = '0; inst_ex_i = '0; taken_ex_i = 1'b0;
    target_ex_i = '0; pred_taken_ex_i = 1'b0; pred_target_ex_i = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_ex();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_counts(input string nm, input logic [31:0] eb, input logic [31:0] em);
    chk({nm, ".branch_cnt"}, branch_cnt_o, eb);
    chk({nm, ".mispred_cnt"}, mispred_cnt_o, em);
    $display("txn %s branch_cnt=%0d mispred_cnt=%0d", nm, branch_cnt_o, mispred_cnt_o);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] e;
    checks = 0;
    failures = 0;
    pc_i = 32'h100;
    // Reset with a live EX transaction that must be ignored.
    rst = 1'b1;
    ex_valid_i = 1'b1; pc_ex_i = 32'h100; inst_ex_i = BEQ; taken_ex_i = 1'b1;
    target_ex_i = 32'h80; pred_taken_ex_i = 1'b0; pred_target_ex_i = 32'h104;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset.pred_taken", {31'b0, pred_taken_o}, 32'h0);
    chk("reset.pred_target", pred_target_o, 32'h104);
    chk("reset.mispredict", {31'b0, mispredict_o}, 32'h1);
    chk("reset.redirect", redirect_pc_o, 32'h80);
    chk_counts("reset", 32'd0, 32'd0);
    clear_ex();

    // Cold BEQ, counter saturation, EX gating, aliasing, wrap.
    vecs.push_back(mk(32'h100, 0, 32'h104, 1, 32'h100, BEQ, 1, 32'h80, 0, 32'h104, 1, 32'h80));
    vecs.push_back(mk(32'h100, 1, 32'h80,  1, 32'h100, BEQ, 1, 32'h80, 1, 32'h80,  0, 32'h80));
    vecs.push_back(mk(32'h100, 1, 32'h80,  1, 32'h100, BEQ, 1, 32'h80, 1, 32'h80,  0, 32'h80));
    vecs.push_back(mk(32'h100, 1, 32'h80,  1, 32'h100, BEQ, 1, 32'h80, 1, 32'h80,  0, 32'h80));
    vecs.push_back(mk(32'h100, 1, 32'h80,  1, 32'h100, BEQ, 0, 32'h80, 1, 32'h80,  1, 32'h104));
    vecs.push_back(mk(32'h100, 1, 32'h80,  1, 32'h100, BEQ, 0, 32'h80, 1, 32'h80,  1, 32'h104));
    vecs.push_back(mk(32'h100, 0, 32'h104, 1, 32'h100, BEQ, 0, 32'h80, 0, 32'h104, 0, 32'h104));
    vecs.push_back(mk(32'h100, 0, 32'h104, 1, 32'h100, BEQ, 0, 32'h80, 0, 32'h104, 0, 32'h104));
    vecs.push_back(mk(32'h100, 0, 32'h104, 1, 32'h100, BEQ, 1, 32'h80, 0, 32'h104, 1, 32'h80));
    vecs.push_back(mk(32'h100, 0, 32'h104, 0, 32'h100, BEQ, 1, 32'h80, 0, 32'h104, 0, 32'h80));
    vecs.push_back(mk(32'h100, 0, 32'h104, 1, 32'h1100, BEQ, 1, 32'h2000, 0, 32'h1104, 1, 32'h2000));
    vecs.push_back(idle(32'h100, 0, 32'h104));
    vecs.push_back(idle(32'h1100, 1, 32'h2000));
    vecs.push_back(mk(32'hFFFF_FFFC, 0, 32'h0, 1, 32'hFFFF_FFFC, BEQ, 0, 32'h40, 0, 32'h0, 0, 32'h0));
    vecs.push_back(mk(32'hFFFF_FFFC, 0, 32'h0, 1, 32'h304, BEQ, 1, 32'h40, 1, 32'h44, 1, 32'h40));
    vecs.push_back(idle(32'h304, 1, 32'h40));

    for (int i = 0; i < vecs.size(); i++) begin
      apply_vec(vecs[i], $sformatf("vec%0d", i));
    end
    @(negedge clk);
    clear_ex();
    #1;
    chk_counts("table", 32'd12, 32'd6);

    // RAS: single call/return, then nested calls beyond the stack depth.
    do_reset();
    apply_vec(mk(32'h400, 0, 32'h404, 1, 32'h200, JAL_X1, 1, 32'h600, 0, 32'h204, 1, 32'h600), "ras.call");
    apply_vec(mk(32'h400, 0, 32'h404, 1, 32'h400, RET, 1, 32'h204, 0, 32'h404, 1, 32'h204), "ras.ret");
    apply_vec(idle(32'h400, 1, 32'h204), "ras.revisit");
    for (int i = 0; i < 5; i++) begin
      e = (i == 0) ? 32'h204 : 32'h504 + 32'(4 * i);
      apply_vec(mk(32'h400, 1, e, 1, 32'h504 + 32'(4 * i), JAL_X1, 1, 32'h800, 1, 32'h800, 0, 32'h800),
                $sformatf("ras.nest%0d", i));
    end
    for (int k = 0; k < 4; k++) begin
      e = 32'h518 - 32'(4 * k);
      apply_vec(mk(32'h400, 1, e, 1, 32'h400, RET, 1, e, 1, e, 0, e), $sformatf("ras.unwind%0d", k));
    end
    apply_vec(idle(32'h400, 1, 32'h50C), "ras.fallback");

    // Pop-then-push replaces the top; underflow is ignored.
    apply_vec(mk(32'h400, 1, 32'h50C, 1, 32'h504, JAL_X1, 1, 32'h800, 1, 32'h800, 0, 32'h800), "ras.push1");
    apply_vec(mk(32'h400, 1, 32'h508, 1, 32'h608, JALR_X1X1, 1, 32'h900, 1, 32'h900, 0, 32'h900), "ras.swap");
    apply_vec(mk(32'h400, 1, 32'h60C, 1, 32'h400, RET, 1, 32'h60C, 1, 32'h60C, 0, 32'h60C), "ras.popswap");
    apply_vec(mk(32'h400, 1, 32'h60C, 1, 32'h400, RET, 1, 32'h60C, 1, 32'h60C, 0, 32'h60C), "ras.underflow");
    apply_vec(mk(32'h400, 1, 32'h60C, 1, 32'h504, JAL_X1, 1, 32'h800, 1, 32'h800, 0, 32'h800), "ras.push2");
    apply_vec(idle(32'h400, 1, 32'h508), "ras.after");

    // Performance counters and mid-run reset.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      apply_vec(mk(32'h700, (i != 0), (i == 0) ? 32'h704 : 32'h40, 1, 32'h700, BEQ, 1, 32'h40,
                   (i >= 3), (i >= 3) ? 32'h40 : 32'h704, (i < 3), 32'h40),
                $sformatf("perf%0d", i));
    end
    @(negedge clk);
    clear_ex();
    #1;
    chk_counts("perf", 32'd10, 32'd3);
    chk("perf.hit", pred_target_o, 32'h40);
    rst = 1'b1;
    ex_valid_i = 1'b1; pc_ex_i = 32'h700; inst_ex_i = BEQ; taken_ex_i = 1'b1;
    target_ex_i = 32'h40; pred_taken_ex_i = 1'b0; pred_target_ex_i = 32'h704;
    @(negedge clk);
    rst = 1'b0;
    clear_ex();
    #1;
    chk_counts("midreset", 32'd0, 32'd0);
    chk("midreset.pred_taken", {31'b0, pred_taken_o}, 32'h0);
    chk("midreset.pred_target", pred_target_o, 32'h704);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
